uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLK_FREQ, default 50000000, meaning the clk frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 9600, meaning the serial bit rate in baud.
REQ-003 The module SHALL have parameter BAUD_COUNT, default CLK_FREQ/BAUD_RATE, meaning clk cycles per bit; legal range 4..65535.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The module SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The module SHALL have port data_out, output, 8 bits: last correctly framed byte.
REQ-008 The module SHALL have port valid, output, 1 bit: one-cycle pulse, data_out updated this cycle.
REQ-009 The module SHALL have port frame_err, output, 1 bit: one-cycle pulse, stop bit sampled low.
REQ-010 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-011 rx SHALL pass through a two-flop synchronizer (both flops reset to 1); rx_s, the second flop, SHALL be the only form of rx used by the FSM.
REQ-012 Frame format SHALL be 8N1: start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, BREAK; a 16-bit down-counter baud_cnt and a 3-bit bit_idx.
REQ-014 In IDLE, rx_s==0 SHALL cause a transition to START with baud_cnt <= BAUD_COUNT/2 - 1 (integer division).
REQ-015 In START, at baud_cnt==0 with rx_s==0, the FSM SHALL enter DATA with baud_cnt <= BAUD_COUNT-1 and bit_idx <= 0.
REQ-016 In START, at baud_cnt==0 with rx_s==1 (glitch/false start), the FSM SHALL return to IDLE with no valid or frame_err pulse.
REQ-017 In DATA, at baud_cnt==0, rx_s SHALL be stored as bit bit_idx of an internal shift register and baud_cnt reloaded to BAUD_COUNT-1; after bit_idx==7 the FSM SHALL enter STOP, else bit_idx increments.
REQ-018 In every state except IDLE and BREAK, baud_cnt SHALL decrement by 1 each cycle it is nonzero.
REQ-019 In STOP, at baud_cnt==0 with rx_s==1, data_out SHALL load the shift register, valid SHALL pulse for exactly one cycle, and the FSM SHALL enter IDLE.
REQ-020 In STOP, at baud_cnt==0 with rx_s==0, frame_err SHALL pulse for one cycle, data_out SHALL hold its previous value, and the FSM SHALL enter BREAK.
REQ-021 In BREAK, the FSM SHALL stay until rx_s==1, then enter IDLE; a held-low line SHALL NOT produce further frames.
REQ-022 Sampling SHALL occur mid-bit: valid SHALL assert BAUD_COUNT/2 + 9*BAUD_COUNT (+/-1) cycles after the first cycle rx_s is low, plus 2 synchronizer cycles relative to rx.
REQ-023 A new start bit SHALL be accepted in the cycle immediately after returning to IDLE (back-to-back frames with no idle gap).
REQ-024 valid and frame_err SHALL never be high in the same cycle; no flow control exists, so an unread byte is overwritten by the next one.

Reset
REQ-025 While rst_n==0: state IDLE, baud_cnt 0, bit_idx 0, shift register 0, data_out 8'h00, valid 0, frame_err 0, busy 0, synchronizer flops 1.
REQ-026 Reset assertion mid-frame SHALL abort the frame immediately, with no valid or frame_err pulse; after release, the line is sampled afresh from IDLE.

Verification (CLK_FREQ=160, BAUD_RATE=10, BAUD_COUNT=16)
REQ-027 Send 8'hA5 at 16 cycles/bit -> single valid pulse, data_out==8'hA5, frame_err never high, busy low afterwards.
REQ-028 Send 8'h00, then 8'hFF back-to-back with no idle gap -> two valid pulses with data_out 8'h00 then 8'hFF.
REQ-029 Pull rx low for 4 cycles only -> FSM returns to IDLE, no valid, no frame_err.
REQ-030 Send 8'h3C with the stop bit driven 0, line then held low 40 cycles -> one frame_err pulse, data_out unchanged, busy high until rx returns high, no further pulses.
REQ-031 Assert rst_n low during data bit 4 of 8'h5A, release, then send 8'h81 -> no pulse for the aborted frame; valid with data_out==8'h81.
REQ-032 Send 8'h96 at baud skew of +/-3% (bit period 15.5/16.5 cycles) -> data_out==8'h96 in both cases.

Source files
------------

// File: rtl/uart_rx.sv
// ============================================================
// uart_rx: 8N1 UART receiver, two-flop synchronized, mid-bit sampling
// Revision: 1.0
// ============================================================
`default_nettype none

module uart_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int BAUD_COUNT = CLK_FREQ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam logic [15:0] HALF_LOAD = 16'(BAUD_COUNT / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(BAUD_COUNT - 1);

    logic        rx_meta;
    logic        rx_s;
    state_t      state,     state_nx;
    logic [15:0] baud_cnt,  baud_cnt_nx;
    logic [2:0]  bit_idx,   bit_idx_nx;
    logic [7:0]  shift_reg, shift_reg_nx;
    logic [7:0]  data_nx;
    logic        valid_nx;
    logic        frame_err_nx;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            data_out  <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            baud_cnt  <= baud_cnt_nx;
            bit_idx   <= bit_idx_nx;
            shift_reg <= shift_reg_nx;
            data_out  <= data_nx;
            valid     <= valid_nx;
            frame_err <= frame_err_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        baud_cnt_nx  = baud_cnt;
        bit_idx_nx   = bit_idx;
        shift_reg_nx = shift_reg;
        data_nx      = data_out;
        valid_nx     = 1'b0;
        frame_err_nx = 1'b0;

        if (state != IDLE && state != BREAK && baud_cnt != 16'd0) begin
            baud_cnt_nx = baud_cnt - 16'd1;
        end

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx    = START;
                    baud_cnt_nx = HALF_LOAD;
                end
            end
            START: begin
                // Re-check the start bit at its midpoint to reject glitches.
                if (baud_cnt == 16'd0) begin
                    if (!rx_s) begin
                        state_nx    = DATA;
                        baud_cnt_nx = FULL_LOAD;
                        bit_idx_nx  = 3'd0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            DATA: begin
                if (baud_cnt == 16'd0) begin
                    shift_reg_nx[bit_idx] = rx_s;
                    baud_cnt_nx           = FULL_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_cnt == 16'd0) begin
                    if (rx_s) begin
                        data_nx  = shift_reg;
                        valid_nx = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        frame_err_nx = 1'b1;
                        state_nx     = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line must return high before another start is seen.
                if (rx_s) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

`default_nettype wire
